// File: rtl/mux_nx1_rr_pkt_pkg.sv
// rtl/mux_nx1_rr_pkt_pkg.sv - shared types for the round-robin packet mux
package mux_nx1_rr_pkt_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_XFER = 1'b1
   } state_e;

endpackage

// File: rtl/mux_nx1_rr_pkt_rr_arbiter.sv
// rtl/mux_nx1_rr_pkt_rr_arbiter.sv - combinational round-robin arbiter
// Picks the first requester after prev_gnt, wrapping modulo N.
module rr_arbiter #(
   parameter int N = 4,
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] prev_gnt,
   output logic [N-1:0]     gnt_onehot,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             any_req
);

   int best_dist;
   int best_i;

   assign any_req = |req;

   // Distance 0 is the index right after prev_gnt; the modulo skips unused codes.
   always_comb begin
      best_dist = N;
      best_i    = 0;
      for (int i = 0; i < N; i++) begin
         if (req[i] && (((i + N - 1 - int'(prev_gnt)) % N) < best_dist)) begin
            best_dist = (i + N - 1 - int'(prev_gnt)) % N;
            best_i    = i;
         end
      end
      gnt_idx = IDX_W'(best_i);
      for (int i = 0; i < N; i++) begin
         gnt_onehot[i] = any_req && (best_i == i);
      end
   end

endmodule

// File: rtl/mux_nx1_rr_pkt.sv
// rtl/mux_nx1_rr_pkt.sv - N-to-1 stream mux with round-robin packet arbitration
// Grant is held for a whole packet (or one beat) and feeds a registered output stage.
module mux_nx1_rr_pkt
   import mux_nx1_rr_pkt_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int NUM_IN   = 4,
   parameter int PKT_MODE = 1,
   localparam int IDX_W   = $clog2(NUM_IN)
) (
   input  logic                     ACLK,
   input  logic                     ARESET,
   input  logic                     enable,
   input  logic [NUM_IN-1:0]        in_valid,
   input  logic [NUM_IN*DATA_W-1:0] in_data,
   input  logic [NUM_IN-1:0]        in_last,
   output logic [NUM_IN-1:0]        in_ready,
   output logic                     out_valid,
   output logic [DATA_W-1:0]        out_data,
   output logic                     out_last,
   input  logic                     out_ready,
   output logic                     gnt_active,
   output logic [IDX_W-1:0]         gnt_idx
);

   state_e              state_q, state_d;
   logic [IDX_W-1:0]    gnt_idx_q, gnt_idx_d;
   logic [NUM_IN-1:0]   gnt_oh_q, gnt_oh_d;
   logic [IDX_W-1:0]    prev_gnt_q, prev_gnt_d;
   logic                out_valid_q, out_valid_d;
   logic [DATA_W-1:0]   out_data_q, out_data_d;
   logic                out_last_q, out_last_d;

   logic [NUM_IN-1:0]   arb_onehot;
   logic [IDX_W-1:0]    arb_idx;
   logic                arb_any;

   logic                out_space;
   logic                accept;
   logic                sel_valid;
   logic                sel_last;
   logic [DATA_W-1:0]   sel_data;

   rr_arbiter #(
      .N (NUM_IN)
   ) u_arb (
      .req        (in_valid),
      .prev_gnt   (prev_gnt_q),
      .gnt_onehot (arb_onehot),
      .gnt_idx    (arb_idx),
      .any_req    (arb_any)
   );

   // AND-OR select keyed by the registered one-hot grant.
   always_comb begin
      sel_data = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         sel_data = sel_data | ({DATA_W{gnt_oh_q[i]}} & in_data[i*DATA_W +: DATA_W]);
      end
   end

   assign sel_valid = |(in_valid & gnt_oh_q);
   assign sel_last  = |(in_last & gnt_oh_q);
   assign out_space = !out_valid_q || out_ready;
   assign in_ready  = ((state_q == ST_XFER) && out_space) ? gnt_oh_q : '0;
   assign accept    = (state_q == ST_XFER) && sel_valid && out_space;

   always_comb begin
      state_d     = state_q;
      gnt_idx_d   = gnt_idx_q;
      gnt_oh_d    = gnt_oh_q;
      prev_gnt_d  = prev_gnt_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;

      if (out_ready) begin
         out_valid_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            if (enable && arb_any) begin
               state_d   = ST_XFER;
               gnt_idx_d = arb_idx;
               gnt_oh_d  = arb_onehot;
            end
         end
         ST_XFER: begin
            if (accept) begin
               out_valid_d = 1'b1;
               out_data_d  = sel_data;
               out_last_d  = sel_last;
               if ((PKT_MODE == 0) || sel_last) begin
                  state_d    = ST_IDLE;
                  prev_gnt_d = gnt_idx_q;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q     <= ST_IDLE;
         gnt_idx_q   <= '0;
         gnt_oh_q    <= '0;
         prev_gnt_q  <= IDX_W'(NUM_IN - 1);
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         gnt_idx_q   <= gnt_idx_d;
         gnt_oh_q    <= gnt_oh_d;
         prev_gnt_q  <= prev_gnt_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign out_last   = out_last_q;
   assign gnt_active = (state_q == ST_XFER);
   assign gnt_idx    = gnt_idx_q;

endmodule
